reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file with an integrated per-register scoreboard for the pipelined LC-3b datapath. It provides two asynchronous read ports and one synchronous write-back port, as its predecessor did. It adds parametrised width and depth, asynchronous reset, and a pending-writer counter per register so decode can detect RAW hazards. It sits between decode (reads and issue) and write-back (register writes).

## Interface
- DATA_W, 16, register width in bits
- ADDR_W, 3, register address width; register count NREGS = 2**ADDR_W
- CNT_W, 2, width of each pending-writer counter; max in-flight writers per register = 2**CNT_W - 1
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- sr1  input  ADDR_W  read port 1 address
- sr2  input  ADDR_W  read port 2 address
- sr1_out  output  DATA_W  read port 1 data
- sr2_out  output  DATA_W  read port 2 data
- sr1_busy  output  1  register sr1 has at least one pending writer
- sr2_busy  output  1  register sr2 has at least one pending writer
- issue_valid  input  1  decode issues an instruction that will write issue_dr
- issue_dr  input  ADDR_W  destination of the issuing instruction
- issue_ready  output  1  issue accepted this cycle when high together with issue_valid
- we  input  1  write-back enable
- dr  input  ADDR_W  write-back destination
- data_in  input  DATA_W  write-back data
- wb_err  output  1  sticky: write-back arrived for a register with pending count 0

## Operation
- Storage: NREGS x DATA_W registers. Pending counters: NREGS x CNT_W. All are cleared to 0 on reset. wb_err resets to 0.
- Reads: sr1_out = reg[sr1] and sr2_out = reg[sr2], combinational. sr1 == sr2 is legal.
- busy: srN_busy = (cnt[srN] != 0), combinational from current counter state.
- Issue handshake: an issue fires when issue_valid && issue_ready.
  - issue_ready is low only when cnt[issue_dr] == max and no write-back to issue_dr occurs this cycle (we && dr == issue_dr).
  - issue_ready does not depend on issue_valid.
- Write-back: when we is high, reg[dr] <= data_in on the clock edge. The write always occurs, regardless of counter state.
- Counter update per clock edge, for each register r:
  - issue fires to r and no write-back to r: cnt += 1.
  - write-back to r and no issue fires to r: cnt -= 1 if cnt != 0. If cnt == 0, cnt stays 0 and wb_err is set.
  - both issue and write-back to r in the same cycle: cnt unchanged, no error. This applies even at cnt == 0 and at cnt == max.
  - neither: unchanged.
- Counter arithmetic is unsigned and never wraps. Saturation is prevented by issue_ready; an underflow attempt is flagged by wb_err.
- wb_err is cleared only by reset.
- Reset asserted mid-operation immediately clears data, counters and wb_err. In-flight writers are forgotten. Reads return 0 during reset.

## Timing
- Read latency: 0 cycles (combinational). A write becomes visible on the read ports the cycle after its edge (without bypass).
- busy latency: an issue at edge N makes busy high from after edge N. A write-back at edge N decrements the counter after edge N.
- issue_ready: combinational from issue_dr, we, dr and the counters. There is no internal state beyond the counters.
- Reset: asynchronous assertion; deassertion is sampled on the rising edge of clk.

## Configuration
- Macro REG_FILE_SB_BYPASS_EN.
- Defined: write-through forwarding.
  - If we && dr == srN, srN_out = data_in in the same cycle.
  - srN_busy reflects the post-write-back count: high only if cnt[srN] - 1 > 0, or an issue to srN fires this cycle.
  - This lets decode consume a result in its write-back cycle.
- Undefined: srN_out always shows stored contents and srN_busy reflects the current count. This gives one extra stall cycle per RAW hazard.

## Test plan
- Reset, then read all registers: every srN_out = 0x0000, both busy = 0, wb_err = 0, issue_ready = 1.
- Issue R3, then 2 cycles later write-back R3 = 0xBEEF: sr1=3 gives busy 1 for 2 cycles, then busy 0 and sr1_out = 0xBEEF. With BYPASS_EN, sr1_out = 0xBEEF and busy 0 already in the write-back cycle.
- Issue R5 three times (CNT_W=2): issue_ready = 0 with issue_dr=5. The same cycle with we=1 and dr=5 gives issue_ready = 1, and the count stays 3.
- Write-back to R2 with count 0 and data 0x1234: reg[2] = 0x1234, count stays 0, wb_err = 1 and stays 1 until reset.
- Issue R1 and write-back R1 in the same cycle at count 0: count stays 0 and wb_err stays 0.
- Assert rst_n low mid-cycle with counters nonzero: outputs go to 0 immediately, before the next edge, and all busy flags are 0 after release.

Source files
------------

// File: rtl/reg_file_sb.sv
// LC-3b register file with per-register pending-writer scoreboard for RAW hazard detection.
// Define REG_FILE_SB_BYPASS_EN to forward write-back data and post-write-back busy to the read ports.
module reg_file_sb #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] sr1,
  input  logic [ADDR_W-1:0] sr2,
  output logic [DATA_W-1:0] sr1_out,
  output logic [DATA_W-1:0] sr2_out,
  output logic              sr1_busy,
  output logic              sr2_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dr,
  output logic              issue_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] dr,
  input  logic [DATA_W-1:0] data_in,
  output logic              wb_err
);

  localparam int NREGS = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];
  logic              issue_fire;
  logic              wb_only;

  // A write-back to a full register frees a slot in the same cycle, so the issue may proceed.
  assign issue_ready = !((cnt[issue_dr] == CNT_MAX) && !(we && (dr == issue_dr)));
  assign issue_fire  = issue_valid && issue_ready;
  assign wb_only     = we && !(issue_fire && (issue_dr == dr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
        cnt[r]  <= '0;
      end
      wb_err <= 1'b0;
    end else begin
      if (we) regs[dr] <= data_in;
      for (int r = 0; r < NREGS; r++) begin
        if (issue_fire && (issue_dr == ADDR_W'(r)) && !(we && (dr == ADDR_W'(r))))
          cnt[r] <= cnt[r] + 1'b1;
        else if (wb_only && (dr == ADDR_W'(r)) && (cnt[r] != '0))
          cnt[r] <= cnt[r] - 1'b1;
      end
      if (wb_only && (cnt[dr] == '0)) wb_err <= 1'b1;
    end
  end

`ifdef REG_FILE_SB_BYPASS_EN
  logic hit1, hit2;
  // Forwarding is suppressed during reset so reads show the cleared storage.
  assign hit1 = rst_n && we && (dr == sr1);
  assign hit2 = rst_n && we && (dr == sr2);

  always_comb begin
    sr1_out  = hit1 ? data_in : regs[sr1];
    sr2_out  = hit2 ? data_in : regs[sr2];
    sr1_busy = hit1 ? ((cnt[sr1] > CNT_W'(1)) || (issue_fire && (issue_dr == sr1)))
                    : (cnt[sr1] != '0);
    sr2_busy = hit2 ? ((cnt[sr2] > CNT_W'(1)) || (issue_fire && (issue_dr == sr2)))
                    : (cnt[sr2] != '0);
  end
`else
  always_comb begin
    sr1_out  = regs[sr1];
    sr2_out  = regs[sr2];
    sr1_busy = (cnt[sr1] != '0);
    sr2_busy = (cnt[sr2] != '0);
  end
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized scoreboard bench for reg_file_sb against a behavioural register/scoreboard model.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  sr1 = '0, sr2 = '0, issue_dr = '0, dr = '0;
  logic [15:0] sr1_out, sr2_out, data_in = '0;
  logic        sr1_busy, sr2_busy, issue_valid = 1'b0, issue_ready, we = 1'b0, wb_err;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .sr1(sr1), .sr2(sr2),
    .sr1_out(sr1_out), .sr2_out(sr2_out), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
    .issue_valid(issue_valid), .issue_dr(issue_dr), .issue_ready(issue_ready),
    .we(we), .dr(dr), .data_in(data_in), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] o1, o2;
    logic        b1, b2, rdy, err;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain arrays of contents and in-flight writer counts.
  int unsigned m_mem [8];
  int unsigned m_cnt [8];
  bit          m_err;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = 0;
      m_cnt[i] = 0;
    end
    m_err = 0;
  endfunction

  function automatic bit model_ready(input int idr, input bit w, input int d);
    return !(m_cnt[idr] == 3 && !(w && d == idr));
  endfunction

  // Apply the inputs that were held across the edge that just occurred.
  function automatic void model_update();
    bit fire;
    if (!rst_n) begin
      model_reset();
      return;
    end
    fire = issue_valid && model_ready(int'(issue_dr), we, int'(dr));
    if (we) m_mem[dr] = data_in;
    if (!(fire && we && dr == issue_dr)) begin
      if (fire) m_cnt[issue_dr] = m_cnt[issue_dr] + 1;
      if (we) begin
        if (m_cnt[dr] == 0) m_err = 1;
        else m_cnt[dr] = m_cnt[dr] - 1;
      end
    end
  endfunction

  function automatic void expect_now();
    exp_t e;
    bit   fire;
    fire  = issue_valid && model_ready(int'(issue_dr), we, int'(dr));
    e.o1  = rst_n ? 16'(m_mem[sr1]) : 16'h0;
    e.o2  = rst_n ? 16'(m_mem[sr2]) : 16'h0;
    e.b1  = rst_n && m_cnt[sr1] != 0;
    e.b2  = rst_n && m_cnt[sr2] != 0;
`ifdef REG_FILE_SB_BYPASS_EN
    if (rst_n && we && dr == sr1) begin
      e.o1 = data_in;
      e.b1 = (m_cnt[sr1] > 1) || (fire && issue_dr == sr1);
    end
    if (rst_n && we && dr == sr2) begin
      e.o2 = data_in;
      e.b2 = (m_cnt[sr2] > 1) || (fire && issue_dr == sr2);
    end
`endif
    e.rdy = rst_n ? model_ready(int'(issue_dr), we, int'(dr)) : 1'b1;
    e.err = rst_n && m_err;
    q.push_back(e);
  endfunction

  task automatic drive(input bit iv, input int idr, input bit w, input int d,
                       input logic [15:0] din, input int a1, input int a2);
    issue_valid = iv;
    issue_dr    = 3'(idr);
    we          = w;
    dr          = 3'(d);
    data_in     = din;
    sr1         = 3'(a1);
    sr2         = 3'(a2);
  endtask

  task automatic step(input bit iv, input int idr, input bit w, input int d,
                      input logic [15:0] din, input int a1, input int a2);
    @(posedge clk);
    model_update();
    #1 drive(iv, idr, w, d, din, a1, a2);
    #1 expect_now();
    ->sample_ev;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: every sample point pops one expectation and compares all outputs.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 required=1 t=%0t", $time);
      end else begin
        e = q.pop_front();
        chk("sr1_out", sr1_out, e.o1);
        chk("sr2_out", sr2_out, e.o2);
        chk("sr1_busy", 16'(sr1_busy), 16'(e.b1));
        chk("sr2_busy", 16'(sr2_busy), 16'(e.b2));
        chk("issue_ready", 16'(issue_ready), 16'(e.rdy));
        chk("wb_err", 16'(wb_err), 16'(e.err));
        $display("txn t=%0t sr1=%0d:%h b%0d sr2=%0d:%h b%0d rdy=%0d err=%0d",
                 $time, sr1, sr1_out, sr1_busy, sr2, sr2_out, sr2_busy, issue_ready, wb_err);
      end
    end
  end

  initial begin
    model_reset();
    #2 expect_now();
    ->sample_ev;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset contents across all registers.
    for (int i = 0; i < 8; i += 2) step(0, 0, 0, 0, 16'h0, i, i + 1);
    // Issue R3, two busy cycles, then write-back 0xBEEF.
    step(1, 3, 0, 0, 16'h0, 3, 3);
    step(0, 0, 0, 0, 16'h0, 3, 0);
    step(0, 0, 0, 0, 16'h0, 3, 0);
    step(0, 0, 1, 3, 16'hBEEF, 3, 3);
    step(0, 0, 0, 0, 16'h0, 3, 3);
    // Saturate R5, then check ready with and without a same-cycle write-back.
    step(1, 5, 0, 0, 16'h0, 5, 0);
    step(1, 5, 0, 0, 16'h0, 5, 0);
    step(1, 5, 0, 0, 16'h0, 5, 0);
    step(1, 5, 0, 0, 16'h0, 5, 0);
    step(1, 5, 1, 5, 16'h5555, 5, 5);
    step(1, 5, 0, 0, 16'h0, 5, 5);
    // Underflowing write-back to R2, then simultaneous issue/write-back of R1 at count 0.
    step(0, 0, 1, 2, 16'h1234, 2, 1);
    step(1, 1, 1, 1, 16'h7777, 2, 1);
    step(0, 0, 0, 0, 16'h0, 2, 1);

    for (int n = 0; n < 300; n++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 4) < 2,
           $urandom_range(0, 7), 16'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));

    // Make R6 busy, then assert reset mid-cycle.
    step(1, 6, 0, 0, 16'h0, 6, 5);
    @(posedge clk);
    model_update();
    #3 rst_n = 1'b0;
    #1 model_reset();
    expect_now();
    ->sample_ev;
    @(posedge clk);
    model_update();
    #1 rst_n = 1'b1;
    drive(0, 0, 0, 0, 16'h0, 6, 5);
    #1 expect_now();
    ->sample_ev;

    for (int n = 0; n < 150; n++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom_range(0, 4) < 2,
           $urandom_range(0, 7), 16'($urandom), $urandom_range(0, 7), $urandom_range(0, 7));

    #2;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
